// File: rtl/seg_scan_controller.sv
// seg_scan_controller: time-multiplexed scan of a 4-digit seven-segment display.
// One nibble and one active-low anode are presented per digit slot, so a single
// segment decoder serves all four digits. Host writes are double-buffered and only
// reach the display at a frame boundary, and each slot opens with a blanking
// interval to suppress ghosting.
module seg_scan_controller #(
  parameter int CLK_DIV      = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_wr_en,
  input  logic [15:0] i_wr_data,
  input  logic [3:0]  i_digit_en,
  output logic [3:0]  o_anode,
  output logic [3:0]  o_disp_val,
  output logic        o_frame_done,
  output logic        o_pending
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYCLES);

  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_DRIVE = 1'b1
  } PhaseT;

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  PhaseT         r_phase;
  logic          r_enQ;
  logic [15:0]   r_activeWord;
  logic [15:0]   r_pendingWord;
  logic          r_pending;

  logic [CW-1:0] w_cntNext;
  logic [1:0]    w_idxNext;
  PhaseT         w_phaseNext;
  logic          w_slotEnd;
  logic          w_boundary;

  // Scan state register: slot counter, digit index and blank/drive phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_idx   <= 2'd0;
      r_phase <= PH_BLANK;
    end else begin
      r_cnt   <= w_cntNext;
      r_idx   <= w_idxNext;
      r_phase <= w_phaseNext;
    end
  end

  // Next-state decode plus all outputs, which depend on registered state only.
  always_comb begin
    w_slotEnd    = 1'b0;
    w_boundary   = 1'b0;
    w_cntNext    = r_cnt + 1'b1;
    w_idxNext    = r_idx;
    w_phaseNext  = PH_DRIVE;
    o_anode      = 4'b1111;
    o_disp_val   = 4'h0;
    o_frame_done = 1'b0;
    o_pending    = r_pending;

    if (r_cnt == CNT_MAX) begin
      w_slotEnd = 1'b1;
      w_cntNext = '0;
      w_idxNext = r_idx + 2'd1;
    end
    w_boundary = w_slotEnd && (r_idx == 2'd3);

    if (w_cntNext < BLANK_LIM) begin
      w_phaseNext = PH_BLANK;
    end

    if ((r_phase == PH_DRIVE) && r_enQ) begin
      o_anode = ~(4'b0001 << r_idx);
    end

    case (r_idx)
      2'd0:    o_disp_val = r_activeWord[3:0];
      2'd1:    o_disp_val = r_activeWord[7:4];
      2'd2:    o_disp_val = r_activeWord[11:8];
      default: o_disp_val = r_activeWord[15:12];
    endcase

    o_frame_done = w_boundary;
  end

  // Latch the digit enable once per slot so a mid-slot change cannot chop a digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_enQ <= 1'b0;
    end else if (r_cnt == '0) begin
      r_enQ <= i_digit_en[r_idx];
    end
  end

  // Double-buffered write path; a write landing on the boundary defers the swap a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_activeWord  <= 16'h0000;
      r_pendingWord <= 16'h0000;
      r_pending     <= 1'b0;
    end else if (i_wr_en) begin
      r_pendingWord <= i_wr_data;
      r_pending     <= 1'b1;
    end else if (w_boundary && r_pending) begin
      r_activeWord <= r_pendingWord;
      r_pending    <= 1'b0;
    end
  end

endmodule

// File: doc/seg_scan_controller.md
# seg_scan_controller

Time-multiplexing scan controller for the 4-digit seven-segment display. It holds a 16-bit display word and steps through the four digits one at a time. For each digit it presents one nibble to the downstream single-digit segment decoder and drives the matching active-low anode, so one decoder serves all four digits. Host writes are double-buffered and take effect only at a frame boundary, which prevents tearing. A blanking interval between digits suppresses ghosting.

## Interface
Parameters:
- CLK_DIV, default 100000: clock cycles per digit slot (1 ms at 100 MHz). Must be ≥ 2.
- BLANK_CYCLES, default 1000: cycles at the start of each slot with all anodes off. Legal range is 0 to CLK_DIV-1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr_en  in  1  one-cycle strobe that writes wr_data into the pending buffer
- wr_data  in  16  display word; [3:0] is digit 0 (rightmost), [15:12] is digit 3 (leftmost)
- digit_en  in  4  per-digit enable; a 0 keeps that anode off for the whole slot
- anode  out  4  active-low digit select; bit i drives digit i
- disp_val  out  4  nibble for the current digit, feeds the segment decoder
- frame_done  out  1  one-cycle pulse on the last cycle of the digit-3 slot
- pending  out  1  high while a written word waits for the next frame boundary

## Operation
State:
- Slot counter cnt counts 0..CLK_DIV-1.
- Digit index idx counts 0..3.
- Phase is BLANK or DRIVE.
- Registers: active_word, pending_word, pending flag, en_q.

Slot behaviour:
- At cnt==0, digit_en[idx] is sampled into en_q.
- Phase is BLANK while cnt < BLANK_CYCLES, otherwise DRIVE.
- When cnt reaches CLK_DIV-1, cnt wraps to 0 and idx increments, with idx wrapping 3 -> 0.

Outputs:
- anode is 4'b1111 in BLANK.
- In DRIVE, anode has only bit idx low if en_q=1, otherwise 4'b1111.
- At most one anode bit is ever low.
- disp_val = active_word[4*idx+3 : 4*idx] for the whole slot, including BLANK, so the decoder settles before the anode turns on.

Frame boundary:
- The boundary is the cycle with idx==3 and cnt==CLK_DIV-1.
- frame_done is high on exactly that cycle.

Write path:
- wr_en loads pending_word and sets pending. Back-to-back writes overwrite; the last write wins.
- On a boundary cycle with pending=1 and wr_en=0, active_word takes pending_word and pending clears on the same edge.
- On a boundary cycle with wr_en=1, the transfer is skipped. pending_word takes the new data and pending stays 1. The new word is applied at the next boundary.

Reset (asynchronous, while rst_n=0 and immediately on assertion):
- cnt=0, idx=0, phase BLANK, en_q=0.
- active_word=0, pending_word=0, pending=0.
- Outputs: anode=4'b1111, disp_val=4'h0, frame_done=0, pending=0.
- Reset asserted mid-slot forces anode to 4'b1111 without waiting for a clock edge.

## Timing
- Slot length is CLK_DIV cycles; frame length is 4*CLK_DIV cycles.
- The first rising edge after rst_n deasserts is cycle 0 of slot 0.
- With BLANK_CYCLES = 0, each DRIVE phase lasts the full slot and en_q is sampled on cycle 0. There are still no overlapping anodes because only one idx is selected at a time.
- All outputs are decoded from registered state only. There is no combinational path from wr_en, wr_data or digit_en to any output.
- pending rises on the edge that samples wr_en.
- Latency from write to display:
  - Display changes at the first slot-0 start after the next boundary without a coincident write.
  - Worst case is 2 frames.

## Test plan
Every scenario uses CLK_DIV=8 and BLANK_CYCLES=2.

- **Reset values:** hold rst_n=0 and check anode=1111, disp_val=0, pending=0, frame_done=0. After release, check anode=1111 on cycles 0–1 and anode=1110 on cycles 2–7 with digit_en=1111.
- **Single write:** write 16'h1234 on cycle 5. Check:
  - pending=1 from cycle 6;
  - frame_done on cycle 31 and pending=0 on cycle 32;
  - next frame shows disp_val 4, 3, 2, 1 with anodes 1110, 1101, 1011, 0111 during DRIVE.
- **Digit masking:** set digit_en=0101. Over a full frame, check anode bits 1 and 3 never go low and bits 0 and 2 behave normally.
- **Write on the boundary:** pulse wr_en with 16'hBEEF exactly on cycle 31. Check no transfer occurs, pending stays 1, the old word is shown for frame 2, and BEEF appears from frame 3.
- **Reset mid-operation:** assert rst_n=0 during DRIVE of digit 2. Check anode=1111 within the same cycle, and that after release the scan restarts at digit 0 with active_word=0.
- **Back-to-back writes:** write 16'h1111 then 16'h2222 on consecutive cycles. Check only 2222 is ever displayed.
